// File: rtl/tune_pkg.sv
// Shared note encoding, pitch tables and FSM state type for the tune player.
package tune_pkg;

  localparam int NOTE_W = 6;
  localparam logic [NOTE_W-1:0] REST_CODE = 6'd0;
  localparam logic [NOTE_W-1:0] END_CODE  = 6'd63;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_PLAY,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [2:0] octave;
    logic [3:0] semi;
  } note_dec_t;

  // Inner divider reload per semitone; half-period = (base+1) * octave scale.
  function automatic logic [8:0] semi_base(input logic [3:0] semi);
    case (semi)
      4'd0:    return 9'd511;
      4'd1:    return 9'd482;
      4'd2:    return 9'd455;
      4'd3:    return 9'd430;
      4'd4:    return 9'd405;
      4'd5:    return 9'd383;
      4'd6:    return 9'd361;
      4'd7:    return 9'd341;
      4'd8:    return 9'd322;
      4'd9:    return 9'd303;
      4'd10:   return 9'd286;
      4'd11:   return 9'd270;
      default: return 9'd511;
    endcase
  endfunction

  function automatic note_dec_t div12(input logic [NOTE_W-1:0] code);
    note_dec_t d;
    d.octave = 3'(code / 6'd12);
    d.semi   = 4'(code % 6'd12);
    return d;
  endfunction

  function automatic logic [7:0] octave_top(input logic [2:0] octave);
    return 8'(8'd255 >> octave);
  endfunction

endpackage

// File: rtl/song_rom.sv
// Song tables with a one-cycle registered read; unprogrammed slots read END_CODE.
module song_rom
  import tune_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int NUM_SONGS = 2,
  parameter int SONG_W    = 1
) (
  input  logic              clk,
  input  logic [SONG_W-1:0] song,
  input  logic [ADDR_W-1:0] addr,
  output logic [NOTE_W-1:0] code
);

  function automatic logic [NOTE_W-1:0] lookup(input int s, input int a);
    if (s >= NUM_SONGS) return END_CODE;
    case (s)
      0: begin
        case (a)
          0:       return 6'd13;
          1:       return REST_CODE;
          2:       return 6'd25;
          default: return END_CODE;
        endcase
      end
      // Song 1 fills eight steps with no end marker, so short address spaces wrap out.
      1: begin
        case (a)
          0:       return 6'd1;
          1:       return 6'd12;
          2:       return REST_CODE;
          3:       return 6'd24;
          4:       return 6'd36;
          5:       return 6'd48;
          6:       return 6'd60;
          7:       return 6'd2;
          default: return END_CODE;
        endcase
      end
      default: return END_CODE;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    code <= lookup(int'(song), int'(addr));
  end

endmodule

// File: rtl/tune_player.sv
// Multi-song square-wave tune player with start/stop, loop and done pulse.
// Optional TUNE_PLAYER_TRANSPOSE_EN adds a signed transpose input.
module tune_player
  import tune_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int NUM_SONGS = 2,
  parameter int TEMPO_DIV = 4194304,
  parameter int GAP_TICKS = 262144,
  localparam int SONG_W   = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [SONG_W-1:0] song_sel,
  input  logic              loop,
`ifdef TUNE_PLAYER_TRANSPOSE_EN
  input  logic signed [3:0] transpose,
`endif
  output logic              speaker,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [NOTE_W-1:0] cur_note
);

  localparam int STEP_W = $clog2(TEMPO_DIV);

  state_t            state;
  logic [SONG_W-1:0] song_q;
  logic [NOTE_W-1:0] rom_code;
  logic [NOTE_W-1:0] fetched;
  logic [STEP_W-1:0] step_cnt;
  logic [8:0]        note_cnt;
  logic [7:0]        oct_cnt;
  note_dec_t         dec;
  logic [8:0]        base;
  logic [7:0]        oct_top;
  logic              gated;
  logic              step_end;

  song_rom #(
    .ADDR_W    (ADDR_W),
    .NUM_SONGS (NUM_SONGS),
    .SONG_W    (SONG_W)
  ) u_rom (
    .clk  (clk),
    .song (song_q),
    .addr (cur_addr),
    .code (rom_code)
  );

`ifdef TUNE_PLAYER_TRANSPOSE_EN
  int shifted;
  always_comb begin
    fetched = rom_code;
    shifted = 0;
    if (rom_code != REST_CODE && rom_code != END_CODE) begin
      shifted = int'(rom_code) + int'(transpose);
      if (shifted < 1)       fetched = 6'd1;
      else if (shifted > 62) fetched = 6'd62;
      else                   fetched = 6'(shifted);
    end
  end
`else
  always_comb begin
    fetched = rom_code;
  end
`endif

  always_comb begin
    dec      = div12(cur_note);
    base     = semi_base(dec.semi);
    oct_top  = octave_top(dec.octave);
    gated    = (step_cnt < STEP_W'(GAP_TICKS)) || (cur_note == REST_CODE);
    step_end = (step_cnt == STEP_W'(TEMPO_DIV - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      song_q   <= '0;
      cur_addr <= '0;
      cur_note <= '0;
      step_cnt <= '0;
      note_cnt <= '0;
      oct_cnt  <= '0;
      speaker  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state    <= ST_IDLE;
        cur_addr <= '0;
        cur_note <= '0;
        step_cnt <= '0;
        note_cnt <= '0;
        oct_cnt  <= '0;
        speaker  <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              song_q   <= song_sel;
              cur_addr <= '0;
              busy     <= 1'b1;
              state    <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            speaker <= 1'b0;
            state   <= ST_WAIT;
          end
          ST_WAIT: begin
            cur_note <= fetched;
            step_cnt <= '0;
            note_cnt <= '0;
            oct_cnt  <= '0;
            if (fetched != END_CODE) begin
              state <= ST_PLAY;
            end else if (loop) begin
              cur_addr <= '0;
              state    <= ST_FETCH;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
          ST_PLAY: begin
            step_cnt <= step_cnt + 1'b1;
            // Silent cycles keep the dividers preloaded so the first edge lands a full half-period after the gap.
            if (gated) begin
              speaker  <= 1'b0;
              note_cnt <= base;
              oct_cnt  <= oct_top;
            end else if (note_cnt == '0) begin
              note_cnt <= base;
              if (oct_cnt == '0) begin
                oct_cnt <= oct_top;
                speaker <= ~speaker;
              end else begin
                oct_cnt <= oct_cnt - 1'b1;
              end
            end else begin
              note_cnt <= note_cnt - 1'b1;
            end
            if (step_end) begin
              speaker <= 1'b0;
              if (!(&cur_addr)) begin
                cur_addr <= cur_addr + 1'b1;
                state    <= ST_FETCH;
              end else if (loop) begin
                cur_addr <= '0;
                state    <= ST_FETCH;
              end else begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= ST_DONE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tune_player.sv
// Bench for tune_player: song vector table plus hand-written reset, stop and tone-timing sequences.
module tb_tune_player;
  import tune_pkg::*;

  localparam int ADDR_W    = 3;
  localparam int NUM_SONGS = 3;
  localparam int TEMPO_DIV = 16;
  localparam int GAP_TICKS = 2;
  localparam int STEP_CYC  = TEMPO_DIV + 2;
  localparam logic [47:0] SONG0_NOTES = {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd25, 6'd0, 6'd13};
  localparam logic [47:0] SONG1_NOTES = {6'd2, 6'd60, 6'd48, 6'd36, 6'd24, 6'd0, 6'd12, 6'd1};

  logic clk = 1'b0;
  logic rst_n, start, stop, loop;
  logic [1:0] song_sel;
  logic speaker, busy, done;
  logic [ADDR_W-1:0] cur_addr;
  logic [5:0] cur_note;

  logic s_start, s_stop, s_loop;
  logic [1:0] s_song;
  logic s_speaker, s_busy, s_done;
  logic [ADDR_W-1:0] s_addr;
  logic [5:0] s_note;

`ifdef TUNE_PLAYER_TRANSPOSE_EN
  logic signed [3:0] transpose = 4'sd0;
`endif

  always #5 clk = ~clk;

  tune_player #(
    .ADDR_W(ADDR_W), .NUM_SONGS(NUM_SONGS), .TEMPO_DIV(TEMPO_DIV), .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .song_sel(song_sel), .loop(loop),
`ifdef TUNE_PLAYER_TRANSPOSE_EN
    .transpose(transpose),
`endif
    .speaker(speaker), .busy(busy), .done(done), .cur_addr(cur_addr), .cur_note(cur_note)
  );

  tune_player #(
    .ADDR_W(ADDR_W), .NUM_SONGS(NUM_SONGS), .TEMPO_DIV(200000), .GAP_TICKS(GAP_TICKS)
  ) dut_slow (
    .clk(clk), .rst_n(rst_n), .start(s_start), .stop(s_stop), .song_sel(s_song), .loop(s_loop),
`ifdef TUNE_PLAYER_TRANSPOSE_EN
    .transpose(transpose),
`endif
    .speaker(s_speaker), .busy(s_busy), .done(s_done), .cur_addr(s_addr), .cur_note(s_note)
  );

  int n_pass = 0;
  int n_total = 0;
  logic [5:0] exp_q[$];

  typedef struct {
    logic [1:0]  song;
    int          len;
    logic [47:0] notes;
    bit          marker;
    int          passes;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [1:0] s);
    start = 1'b1;
    song_sel = s;
    tick(1);
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    bit spk_hi, done_hi;
    logic [5:0] e;
    for (int p = 0; p <= v.passes; p++) begin
      loop = (p < v.passes);
      if (p == 0) begin
        pulse_start(v.song);
        check("busy_rise", busy, 1);
        check("addr_start", cur_addr, 0);
      end
      for (int k = 0; k < v.len; k++) exp_q.push_back(v.notes[k*6 +: 6]);
      for (int k = 0; k < v.len; k++) begin
        tick(2);
        e = exp_q.pop_front();
        check("step_note", cur_note, e);
        check("step_addr", cur_addr, k);
        check("step_busy", busy, 1);
        spk_hi = 0;
        done_hi = 0;
        for (int c = 0; c < TEMPO_DIV; c++) begin
          if (speaker !== 1'b0) spk_hi = 1;
          if (done !== 1'b0) done_hi = 1;
          tick(1);
        end
        check("step_quiet", spk_hi, 0);
        check("step_no_done", done_hi, 0);
      end
      if (v.marker) tick(2);
      if (p < v.passes) begin
        check("loop_no_done", done, 0);
        check("loop_busy", busy, 1);
        check("loop_addr", cur_addr, 0);
      end else begin
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_spk", speaker, 0);
        check("done_note", cur_note, v.marker ? END_CODE : v.notes[(v.len-1)*6 +: 6]);
        tick(1);
        check("done_width", done, 0);
      end
    end
  endtask

  initial begin
    int n;
    bit done_hi;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; song_sel = 2'd0;
    s_start = 1'b0; s_stop = 1'b0; s_loop = 1'b0; s_song = 2'd0;

    vecs[0] = '{song: 2'd0, len: 3, notes: SONG0_NOTES, marker: 1'b1, passes: 0};
    vecs[1] = '{song: 2'd1, len: 8, notes: SONG1_NOTES, marker: 1'b0, passes: 0};
    vecs[2] = '{song: 2'd0, len: 3, notes: SONG0_NOTES, marker: 1'b1, passes: 1};
    vecs[3] = '{song: 2'd1, len: 8, notes: SONG1_NOTES, marker: 1'b0, passes: 1};
    vecs[4] = '{song: 2'd3, len: 0, notes: '0, marker: 1'b1, passes: 0};
    vecs[5] = '{song: 2'd2, len: 0, notes: '0, marker: 1'b1, passes: 0};

    #3;
    check("rst_speaker", speaker, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", cur_addr, 0);
    check("rst_note", cur_note, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      tick(3);
    end

    // Asynchronous reset in the middle of a played note
    pulse_start(2'd0);
    tick(2 + 2 * STEP_CYC);
    check("pre_rst_note", cur_note, 25);
    check("pre_rst_addr", cur_addr, 2);
    #3 rst_n = 1'b0;
    #1;
    check("arst_speaker", speaker, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_addr", cur_addr, 0);
    check("arst_note", cur_note, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);

    // Stop wins over a simultaneous start
    start = 1'b1; stop = 1'b1; song_sel = 2'd0;
    tick(1);
    start = 1'b0; stop = 1'b0;
    check("stopstart_busy", busy, 0);
    tick(3);
    check("stopstart_busy_late", busy, 0);
    check("stopstart_note", cur_note, 0);

    // Start while busy is ignored, then stop mid-PLAY
    pulse_start(2'd0);
    tick(2 + STEP_CYC);
    start = 1'b1; song_sel = 2'd1;
    tick(1);
    start = 1'b0;
    tick(1);
    check("busy_start_addr", cur_addr, 1);
    check("busy_start_busy", busy, 1);
    tick(STEP_CYC - 2);
    check("busy_start_note", cur_note, 25);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_spk", speaker, 0);
    check("stop_addr", cur_addr, 0);
    check("stop_note", cur_note, 0);
    done_hi = 0;
    for (int c = 0; c < 5; c++) begin
      if (done !== 1'b0) done_hi = 1;
      tick(1);
    end
    check("stop_no_done", done_hi, 0);

    // Tone timing on a long-tempo instance: note 13 -> half period 483*128 after the gap
    s_song = 2'd0;
    s_start = 1'b1;
    tick(1);
    s_start = 1'b0;
    tick(2);
    check("slow_gap_quiet", s_speaker, 0);
    check("slow_note", s_note, 13);
    n = 0;
    while (s_speaker !== 1'b1 && n < 70000) begin
      tick(1);
      n++;
    end
    check("slow_first_toggle", n, GAP_TICKS + 483 * 128);
    check("slow_busy", s_busy, 1);
    s_stop = 1'b1;
    tick(1);
    s_stop = 1'b0;
    check("slow_stop_spk", s_speaker, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tune_player.md
Name: tune_player

Overview:
Parametrised multi-song square-wave tune player, the next generation of the board's single-tune speaker driver.
- Adds a start/stop handshake, song select, loop mode, configurable tempo and note-gap timing, a one-cycle done pulse, and a runtime status readout.
- Sits between game control logic (title/game-over/run events) and the speaker pin.

Parameters:
ADDR_W, 8, ROM address width per song; max song length 2**ADDR_W steps
NUM_SONGS, 2, number of songs in ROM; SONG_W = max(1, $clog2(NUM_SONGS))
TEMPO_DIV, 4194304, clk cycles per note step in PLAY state (>=4)
GAP_TICKS, 262144, silent clk cycles at the start of each step for articulation (< TEMPO_DIV)

Ports:
clk  in  1  system clock (25 MHz nominal)
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin playback
stop  in  1  abort playback
song_sel  in  SONG_W  song index, sampled only when start is accepted
loop  in  1  at end of song restart at step 0 instead of finishing; sampled every cycle
speaker  out  1  square-wave output
busy  out  1  high from start acceptance until IDLE/DONE
done  out  1  one-cycle pulse when a song ends without loop
cur_addr  out  ADDR_W  current step address
cur_note  out  6  current note code

Behaviour:
- Reset (async, rst_n=0): state IDLE; speaker=0, busy=0, done=0, cur_addr=0, cur_note=0; all counters 0.
- Note code is 6 bits. 0 = rest. 63 = end marker. Otherwise octave = code/12 (0..5) and semi = code%12.
- Half-period length in cycles = (BASE[semi]+1) * ((255>>octave)+1).
  - BASE = {511,482,455,430,405,383,361,341,322,303,286,270}.
  - Implemented as nested note/octave down-counters. speaker toggles when both counters hit 0.
- FSM states: IDLE, FETCH, WAIT, PLAY, DONE.
  - IDLE/DONE + start: latch song_sel, cur_addr=0, go to FETCH. busy rises on the same edge.
  - FETCH: present {song, cur_addr} to the ROM. Next state WAIT.
  - WAIT: ROM data (1-cycle registered) is captured into cur_note.
    - If the code is 63, end handling applies.
    - Otherwise go to PLAY with step counter = 0 and note/octave counters = 0.
  - PLAY: step counter increments each cycle.
    - At TEMPO_DIV-1, cur_addr increments and the FSM goes to FETCH.
    - If cur_addr = 2**ADDR_W-1, end handling applies instead.
- Latency: the first PLAY cycle is the 3rd edge after the start edge. Each step lasts TEMPO_DIV+2 cycles.
- Gap: speaker is held 0 while step counter < GAP_TICKS, and for rest notes; toggling resumes afterwards.
- End handling:
  - If loop=1: cur_addr=0, go to FETCH, busy stays 1, no done pulse.
  - Else: go to DONE, busy=0, done=1 for exactly one cycle, speaker=0.
- DONE behaves as IDLE; it only reflects that the last song finished.
- stop (any state): on the next edge the FSM goes to IDLE. speaker=0, busy=0, no done pulse, cur_addr/cur_note cleared. stop wins over a simultaneous start.
- start while busy is ignored.
- song_sel >= NUM_SONGS: the ROM returns 63, so the song ends immediately (done pulse, or endless FETCH/WAIT cycling with loop=1).

Optional Feature:
TUNE_PLAYER_TRANSPOSE_EN
- Defined: adds input port transpose (4-bit signed, -8..+7), sampled every cycle.
  - Non-rest, non-end codes become code+transpose, saturated to 1..62 before octave/semi decode.
  - cur_note shows the transposed value.
- Undefined: no port; codes are used as stored.

Decomposition:
- Package tune_pkg holds:
  - note code width 6;
  - REST_CODE=0 and END_CODE=63;
  - the 12-entry BASE table as a function semi_base(semi);
  - a divide-by-12 function returning octave/semi;
  - the state enum.
- One sub-module, song_rom (clk, song, addr -> registered 6-bit code), holds all song tables. Unprogrammed addresses return END_CODE.

Test Plan:
(Bench params: ADDR_W=3, TEMPO_DIV=16, GAP_TICKS=2; test ROM song0 = {13,0,25,63}.)
1. Reset mid-PLAY: drop rst_n -> speaker, busy, done, cur_addr, cur_note all 0 in the same cycle, before any clock edge.
2. start, song_sel=0, loop=0 -> busy rises next edge; PLAY 3 edges after start; cur_note sequence 13,0,25; done pulses once at step 3 (END_CODE); busy falls.
3. Note 13 (octave 1, semi 1): speaker period = 2*483*128 cycles, but a 16-cycle step gives no toggle. Rerun with TEMPO_DIV=200000 -> first toggle at GAP_TICKS+483*128 cycles into the step.
4. loop=1 -> after step 2, cur_addr returns to 0 with no done pulse and busy held. Deassert loop -> next end pulses done.
5. stop asserted together with start in IDLE -> stays IDLE. stop mid-PLAY -> IDLE next edge, speaker=0, no done pulse.
6. song_sel=3 (NUM_SONGS=2), loop=0 -> done pulses 3 cycles after start, speaker never toggles.
